// File: rtl/sb_arb_pkg.sv
// rtl/sb_arb_pkg.sv - shared state encoding and transaction codes for the sideband arbiter
//
// Contents:
//   arb_state_t     2-bit arbiter state (IDLE / ISSUE / WAIT / GAP)
//   TRANS_NONE      select code meaning "no transaction"
//   TRANS_*         transaction select codes understood by the generator FSM
package sb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_t;

    localparam logic [2:0] TRANS_NONE       = 3'd0;
    localparam logic [2:0] TRANS_LINK_REQ   = 3'd1;
    localparam logic [2:0] TRANS_LINK_RSP   = 3'd2;
    localparam logic [2:0] TRANS_REG_RD_CPL = 3'd3;
    localparam logic [2:0] TRANS_REG_WR_CPL = 3'd4;
    localparam logic [2:0] TRANS_DISCONNECT = 3'd5;
    localparam logic [2:0] TRANS_DBG_MSG    = 3'd6;
    localparam logic [2:0] TRANS_VENDOR     = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick with an external start pointer
//
// Ports:
//   req    in   N   request vector (bit j = round-robin slot j)
//   ptr    in   PW  slot searched first; search wraps upward from here
//   grant  out  N   one-hot grant, zero when nothing requests
//   valid  out  1   some slot was granted
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    always_comb begin
        int pos;
        grant = '0;
        valid = 1'b0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            // constant inner index keeps the selects static after unrolling
            for (int j = 0; j < N; j++) begin
                if (!valid && (j == pos) && req[j]) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sb_trans_arbiter.sv
// rtl/sb_trans_arbiter.sv - shares the sideband transaction generator among requesters
//
// Ports:
//   sb_clk        in   1          sideband clock
//   rst           in   1          asynchronous active-low reset
//   req           in   NUM_REQ    level request per requester
//   req_code      in   3*NUM_REQ  select code per requester, slice i = [3i+2:3i]
//   disconnected  in   1          only requester 0 may be served while high
//   gen_busy      in   1          generator cannot accept a new select code
//   trans_sent    in   1          generator finished the current transaction
//   trans_sel     out  3          select code, nonzero for one cycle per transaction
//   ack           out  NUM_REQ    one-hot completion pulse to the owner
//   err           out  NUM_REQ    one-hot timeout pulse to the owner
//   owner         out  log2(N)    current or last granted requester
//   active        out  1          high from issue until the gap ends
module sb_trans_arbiter
    import sb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic                     sb_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [3*NUM_REQ-1:0]     req_code,
    input  logic                     disconnected,
    input  logic                     gen_busy,
    input  logic                     trans_sent,
    output logic [2:0]               trans_sel,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       err,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                     active
);

    localparam int OW  = $clog2(NUM_REQ);
    localparam int NRR = NUM_REQ - 1;

    arb_state_t         state, state_next;
    logic [OW-1:0]      rr_ptr;
    logic [CW-1:0]      timer;
    logic [CW-1:0]      gap_cnt;

    logic [NUM_REQ-1:0] elig;
    logic [NRR-1:0]     rr_grant;
    logic               rr_valid;
    logic [OW-1:0]      sel_idx;
    logic [2:0]         sel_code;
    logic [NUM_REQ-1:0] owner_oh;
    logic               do_grant;
    logic               do_ack;
    logic               do_err;

    // a zero code never issues; disconnect masks everyone except requester 0
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (req_code[3*i +: 3] != TRANS_NONE) &&
                      ((i == 0) || !disconnected);
        end
    end

    // round-robin slot j is requester j+1, so the pointer is shifted down by one
    rr_arbiter #(
        .N  (NRR),
        .PW (OW)
    ) u_rr (
        .req   (elig[NUM_REQ-1:1]),
        .ptr   (rr_ptr - OW'(1)),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    // requester 0 overrides the round-robin result
    always_comb begin
        sel_idx  = '0;
        sel_code = req_code[2:0];
        if (!elig[0]) begin
            for (int i = 1; i < NUM_REQ; i++) begin
                if (rr_grant[i-1]) begin
                    sel_idx  = OW'(i);
                    sel_code = req_code[3*i +: 3];
                end
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner == OW'(i));
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_ack     = 1'b0;
        do_err     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if ((elig[0] || rr_valid) && !gen_busy) begin
                    do_grant   = 1'b1;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_next = ARB_WAIT;
            ARB_WAIT: begin
                // completion takes precedence over a coincident timeout
                if (trans_sent) begin
                    do_ack     = 1'b1;
                    state_next = ARB_GAP;
                end else if (timer == CW'(TIMEOUT - 1)) begin
                    do_err     = 1'b1;
                    state_next = ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (gap_cnt == '0) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // trans_sel is loaded on the grant edge so it is visible in the ISSUE cycle;
    // the timer also runs through ISSUE, so the abort lands TIMEOUT cycles after it
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            trans_sel <= TRANS_NONE;
            ack       <= '0;
            err       <= '0;
            owner     <= '0;
            active    <= 1'b0;
            rr_ptr    <= OW'(1);
            timer     <= '0;
            gap_cnt   <= '0;
        end else begin
            trans_sel <= TRANS_NONE;
            ack       <= do_ack ? owner_oh : '0;
            err       <= do_err ? owner_oh : '0;

            if (do_grant) begin
                owner     <= sel_idx;
                trans_sel <= sel_code;
                active    <= 1'b1;
                timer     <= '0;
            end else if ((state == ARB_ISSUE) || (state == ARB_WAIT)) begin
                timer <= timer + 1'b1;
            end

            if (do_ack || do_err) begin
                gap_cnt <= CW'(MIN_GAP);
                if (owner != '0) begin
                    rr_ptr <= (owner == OW'(NUM_REQ - 1)) ? OW'(1) : owner + OW'(1);
                end
            end

            if (state == ARB_GAP) begin
                if (gap_cnt == '0) begin
                    active <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_trans_arbiter.sv
// tb/tb_sb_trans_arbiter.sv - self-checking bench for sb_trans_arbiter
module tb_sb_trans_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 1024;
    localparam int CW      = 11;
    localparam int NV      = 10;

    logic        sb_clk       = 1'b0;
    logic        rst          = 1'b0;
    logic [3:0]  req          = '0;
    logic [11:0] req_code     = '0;
    logic        disconnected = 1'b0;
    logic        gen_busy     = 1'b0;
    logic        trans_sent   = 1'b0;
    logic [2:0]  trans_sel;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [1:0]  owner;
    logic        active;

    always #5 sb_clk = ~sb_clk;

    sb_trans_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .sb_clk       (sb_clk),
        .rst          (rst),
        .req          (req),
        .req_code     (req_code),
        .disconnected (disconnected),
        .gen_busy     (gen_busy),
        .trans_sent   (trans_sent),
        .trans_sel    (trans_sel),
        .ack          (ack),
        .err          (err),
        .owner        (owner),
        .active       (active)
    );

    typedef struct {
        logic [1:0] owner;
        logic [2:0] code;
    } grant_t;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] code;
        logic        disc;
        logic        exp_issue;
        int          exp_owner;
        int          exp_code;
    } vec_t;

    grant_t     exp_q[$];
    vec_t       vec[NV];
    int         checks         = 0;
    int         failures       = 0;
    int         cyc            = 0;
    int         issue_cnt      = 0;
    int         last_issue_cyc = 0;
    int         last_ack_cyc   = 0;
    logic [2:0] prev_sel       = '0;

    always @(posedge sb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string why);
        checks++;
        failures++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    // scoreboard side: every issue must match the oldest expected grant
    always @(negedge sb_clk) begin
        grant_t g;
        if (rst) begin
            if (trans_sel != 3'd0) begin
                check("sel_single_cycle", 32'(prev_sel), 32'd0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_issue", $sformatf("code %0d owner %0d", trans_sel, owner));
                end else begin
                    g = exp_q.pop_front();
                    check("issue_code", 32'(trans_sel), 32'(g.code));
                    check("issue_owner", 32'(owner), 32'(g.owner));
                end
                issue_cnt++;
                last_issue_cyc = cyc;
            end
            if ((ack | err) != 4'd0) begin
                check("ack_err_exclusive", 32'((ack != 4'd0) && (err != 4'd0)), 32'd0);
                check("resp_onehot", 32'($onehot(ack | err)), 32'd1);
            end
        end
        prev_sel = trans_sel;
    end

    task automatic step();
        @(negedge sb_clk);
        #1;
    endtask

    task automatic expect_grant(input int o, input int c);
        grant_t g;
        g.owner = 2'(o);
        g.code  = 3'(c);
        exp_q.push_back(g);
    endtask

    task automatic wait_issue(input int bound, output int at);
        int start;
        start = issue_cnt;
        at    = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (issue_cnt != start) begin
                at = last_issue_cyc;
                break;
            end
        end
        if (at < 0) fail("issue_wait", "no issue within bound");
    endtask

    // pulse trans_sent dly cycles after the ISSUE cycle and check the ack that follows
    task automatic complete(input int issue_at, input int dly, input int idx, input bit drop);
        while (cyc < issue_at + dly) step();
        trans_sent = 1'b1;
        step();
        trans_sent = 1'b0;
        check("ack", 32'(ack), 32'(1) << idx);
        check("no_err_on_ack", 32'(err), 32'd0);
        last_ack_cyc = cyc;
        if (drop) req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        req          = '0;
        trans_sent   = 1'b0;
        gen_busy     = 1'b0;
        disconnected = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time bound exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int ic, rc, n;
        int order[5];
        logic [3:0] ack_seen, err_early;

        //            req      {c3,c2,c1,c0}                   disc  iss  own code
        vec[0] = '{4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, 1'b0, 1'b1, 1, 2};
        vec[1] = '{4'b0001, {3'd1, 3'd1, 3'd1, 3'd0}, 1'b0, 1'b0, 0, 0};
        vec[2] = '{4'b0011, {3'd0, 3'd0, 3'd3, 3'd0}, 1'b0, 1'b1, 1, 3};
        vec[3] = '{4'b1100, {3'd5, 3'd4, 3'd0, 3'd0}, 1'b0, 1'b1, 2, 4};
        vec[4] = '{4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 1'b1, 1'b0, 0, 0};
        vec[5] = '{4'b1001, {3'd6, 3'd0, 3'd0, 3'd5}, 1'b1, 1'b1, 0, 5};
        vec[6] = '{4'b1111, {3'd7, 3'd7, 3'd7, 3'd7}, 1'b0, 1'b1, 0, 7};
        vec[7] = '{4'b0000, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b0, 1'b0, 0, 0};
        vec[8] = '{4'b1110, {3'd1, 3'd0, 3'd0, 3'd2}, 1'b0, 1'b1, 3, 1};
        vec[9] = '{4'b0110, {3'd2, 3'd3, 3'd4, 3'd0}, 1'b0, 1'b1, 1, 4};

        // reset state
        step();
        step();
        check("rst_trans_sel", 32'(trans_sel), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        rst = 1'b1;

        // single request, completion, gap
        req_code = {3'd0, 3'd0, 3'd2, 3'd0};
        expect_grant(1, 2);
        req = 4'b0010;
        rc  = cyc;
        wait_issue(10, ic);
        check("t1_latency", 32'(ic - rc), 32'd1);
        check("t1_active_issue", 32'(active), 32'd1);
        complete(ic, 20, 1, 1'b1);
        while (cyc < last_ack_cyc + MIN_GAP) step();
        check("t1_active_in_gap", 32'(active), 32'd1);
        step();
        check("t1_active_after_gap", 32'(active), 32'd0);

        // eligibility and priority vectors, each from reset
        for (int k = 0; k < NV; k++) begin
            do_reset();
            req_code     = vec[k].code;
            disconnected = vec[k].disc;
            if (vec[k].exp_issue) expect_grant(vec[k].exp_owner, vec[k].exp_code);
            n   = issue_cnt;
            req = vec[k].req;
            rc  = cyc;
            if (vec[k].exp_issue) begin
                wait_issue(8, ic);
                check("vec_latency", 32'(ic - rc), 32'd1);
                complete(ic, 2, vec[k].exp_owner, 1'b1);
                req = '0;
            end else begin
                repeat (8) step();
                check("vec_no_issue", 32'(issue_cnt - n), 32'd0);
            end
        end

        // held round-robin requests with gap spacing
        do_reset();
        req_code = {3'd3, 3'd2, 3'd1, 3'd0};
        order    = '{1, 2, 3, 1, 2};
        for (int k = 0; k < 5; k++) expect_grant(order[k], order[k]);
        req = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            wait_issue(20, ic);
            if (k > 0) check("t2_gap_spacing", 32'(ic - last_ack_cyc), 32'(MIN_GAP + 2));
            complete(ic, 5, order[k], 1'b0);
        end
        req = '0;

        // requester 0 priority and pointer preservation
        do_reset();
        req_code = {3'd7, 3'd6, 3'd1, 3'd4};
        expect_grant(0, 4);
        expect_grant(2, 6);
        req = 4'b0101;
        wait_issue(10, ic);
        complete(ic, 3, 0, 1'b1);
        wait_issue(20, ic);
        complete(ic, 3, 2, 1'b1);
        expect_grant(0, 4);
        expect_grant(3, 7);
        expect_grant(1, 1);
        req = 4'b1011;
        wait_issue(20, ic);
        complete(ic, 3, 0, 1'b1);
        wait_issue(20, ic);
        complete(ic, 3, 3, 1'b1);
        wait_issue(20, ic);
        complete(ic, 3, 1, 1'b1);

        // timeout abort, then the next request is served
        expect_grant(2, 6);
        expect_grant(3, 7);
        req = 4'b1100;
        wait_issue(20, ic);
        ack_seen  = '0;
        err_early = '0;
        while (cyc < ic + TIMEOUT - 1) begin
            step();
            ack_seen  = ack_seen | ack;
            err_early = err_early | err;
        end
        check("t4_no_early_err", 32'(err_early), 32'd0);
        step();
        check("t4_err", 32'(err), 32'b0100);
        check("t4_no_ack", 32'(ack | ack_seen), 32'd0);
        last_ack_cyc = cyc;
        req[2] = 1'b0;
        wait_issue(20, ic);
        check("t4_next_spacing", 32'(ic - last_ack_cyc), 32'(MIN_GAP + 2));
        complete(ic, 2, 3, 1'b1);

        // disconnect masking and generator busy
        do_reset();
        req_code     = {3'd0, 3'd5, 3'd3, 3'd5};
        disconnected = 1'b1;
        req          = 4'b0110;
        n = issue_cnt;
        repeat (10) step();
        check("t5_disc_blocks", 32'(issue_cnt - n), 32'd0);
        expect_grant(0, 5);
        req[0] = 1'b1;
        rc     = cyc;
        wait_issue(10, ic);
        check("t5_urgent_latency", 32'(ic - rc), 32'd1);
        complete(ic, 4, 0, 1'b1);
        disconnected = 1'b0;
        gen_busy     = 1'b1;
        n = issue_cnt;
        repeat (15) step();
        check("t5_busy_blocks", 32'(issue_cnt - n), 32'd0);
        expect_grant(1, 3);
        expect_grant(2, 5);
        gen_busy = 1'b0;
        rc       = cyc;
        wait_issue(10, ic);
        check("t5_busy_release", 32'(ic - rc), 32'd1);
        complete(ic, 2, 1, 1'b1);
        wait_issue(20, ic);
        complete(ic, 2, 2, 1'b1);

        // asynchronous reset in the middle of WAIT
        req_code = {3'd0, 3'd0, 3'd2, 3'd0};
        expect_grant(1, 2);
        req = 4'b0010;
        wait_issue(20, ic);
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("t6_async_sel", 32'(trans_sel), 32'd0);
        check("t6_async_active", 32'(active), 32'd0);
        check("t6_async_owner", 32'(owner), 32'd0);
        check("t6_async_ack_err", 32'({ack, err}), 32'd0);
        step();
        step();
        expect_grant(1, 2);
        rst = 1'b1;
        rc  = cyc;
        wait_issue(10, ic);
        check("t6_reissue_latency", 32'(ic - rc), 32'd1);
        complete(ic, 2, 1, 1'b1);

        repeat (8) step();
        check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_trans_arbiter.md
Name: sb_trans_arbiter

Overview:
Shares the sideband transaction generator among several requesters: link-state control, register-access responses, and software/debug injection. It picks one pending request, drives the 3-bit transaction select code for one cycle, then waits for the generator's sent indication. It enforces a minimum inter-transaction gap and a watchdog timeout. It sits in the sb_clk domain, between the requester logic and the transaction generator FSM.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is the urgent, fixed-priority requester (link control/disconnect).
MIN_GAP, 4, idle sb_clk cycles enforced after each completed or aborted transaction (0 allowed).
TIMEOUT, 1024, sb_clk cycles allowed between issue and trans_sent before abort.
CW, 11, counter width; must satisfy 2^CW > max(TIMEOUT, MIN_GAP).

Ports:
sb_clk  in  1  sideband clock
rst  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester, held until its ack or err pulse
req_code  in  3*NUM_REQ  transaction select code per requester; slice i = bits [3i+2:3i]
disconnected  in  1  sideband disconnected; only requester 0 is eligible while high
gen_busy  in  1  generator cannot accept a new select code
trans_sent  in  1  one-cycle pulse from the generator: transaction fully transmitted
trans_sel  out  3  select code to the generator; nonzero for exactly one cycle per transaction
ack  out  NUM_REQ  one-hot, one-cycle pulse to the owner on trans_sent
err  out  NUM_REQ  one-hot, one-cycle pulse to the owner on timeout
owner  out  $clog2(NUM_REQ)  index of the current or last granted requester
active  out  1  high from issue until the gap ends

Behaviour:
- Reset is asynchronous active-low (rst). Reset values: trans_sel=0, ack=0, err=0, owner=0, active=0, state=IDLE, rr_ptr=1, counters=0.
- Eligibility: requester i is eligible when req[i]=1 and its code is nonzero. For i>0, disconnected must also be 0. A code of 0 is never issued; that request stays pending without effect.
- Selection: requester 0 wins if eligible. Otherwise, round-robin over indices 1..NUM_REQ-1, starting at rr_ptr. On completion or abort by requester k>0, rr_ptr is set to k+1, wrapping to 1. A grant to requester 0 leaves rr_ptr unchanged.
- FSM states:
  - IDLE: when any requester is eligible and gen_busy=0, latch the owner and the code, and go to ISSUE. The code is sampled in this cycle; later changes to it are ignored.
  - ISSUE (1 cycle): trans_sel = latched code; active=1; clear the timer; go to WAIT.
  - WAIT: trans_sel=0; the timer increments every cycle.
    - trans_sent=1: ack[owner] pulses in the next cycle; go to GAP.
    - Timer reaches TIMEOUT-1 with no trans_sent: err[owner] pulses in the next cycle; go to GAP.
    - trans_sent and timeout in the same cycle: trans_sent wins; ack pulses, err does not.
  - GAP: load the gap counter with MIN_GAP and count down. Go to IDLE when it reaches 0; active drops in that transition cycle. With MIN_GAP=0, GAP lasts exactly one cycle.
- Latency: minimum of 1 cycle from eligible request (with gen_busy=0) to nonzero trans_sel. From trans_sent to ack there is 1 cycle.
- trans_sent outside WAIT is ignored; it causes no ack and no state change.
- Dropping req during WAIT does not abort the transaction; ack still pulses. The requester must then ignore it.
- disconnected rising during WAIT does not abort the transaction; it only affects eligibility at the next IDLE selection.
- ack and err are never high together; at most one bit of each is set.
- trans_sel is registered. No combinational path exists from inputs to outputs.

Decomposition:
- Shared package (sb_arb_pkg): 2-bit state encoding (IDLE/ISSUE/WAIT/GAP), TRANS_NONE=3'd0 constant, and transaction code constants shared with the generator FSM.
- One natural sub-module, rr_arbiter: combinational round-robin pick over NUM_REQ-1 requesters with a pointer input. It returns a one-hot grant and a valid flag. Priority for requester 0 stays in the top level.

Test Plan:
1. Reset, then req=4'b0010 with code 3'd2 and gen_busy=0 → trans_sel=2 for exactly one cycle, 1 cycle after req. Pulse trans_sent 20 cycles later → ack=4'b0010 1 cycle later; active stays high until MIN_GAP=4 idle cycles have elapsed.
2. req=4'b1110 held with codes 1,2,3, generator acks each after 5 cycles → grant order 1,2,3,1,2,… The next trans_sel is never earlier than 4 cycles after the previous ack.
3. req[0] and req[2] asserted in the same cycle → requester 0 issues first, then 2. rr_ptr is unaffected by requester 0's grant.
4. No trans_sent after issue → err[owner] pulses exactly TIMEOUT cycles after the ISSUE cycle, with no ack. The arbiter then returns to IDLE and serves the next request.
5. disconnected=1 with req=4'b0110 → no trans_sel. Then asserting req[0] with code 3'd5 → trans_sel=5. gen_busy=1 holds IDLE with no issue until it deasserts.
6. Assert rst mid-WAIT → all outputs are 0 immediately (asynchronously). After release, a pending request is reissued starting from IDLE.
